register_file_sb: RTL and testbench

Parametrised multi-read-port register file with a per-register pending-write scoreboard for the pipelined RV32I core. It replaces the fixed 32x32, two-read-port register file:
- register count, data width and read-port count are generic;
- an optional write-to-read bypass is selectable;
- busy bits flag registers with an outstanding writer, so the decode stage can detect RAW hazards without a separate hazard table.

It sits between decode (reads, reservation) and writeback (write).

---
 rtl/register_file_sb.sv | 115 +++++++++++
 tb/tb_register_file_sb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// register_file_sb: parametrised multi-read-port register file with a
// per-register pending-write (busy) scoreboard. Register 0 reads as zero
// and is never busy. Reads are combinational, with optional same-cycle
// forwarding of the writeback data.
module register_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [ADDR_W-1:0]              rd,
    input  logic [DATA_W-1:0]              register_file_data,
    input  logic [NUM_READ*ADDR_W-1:0]     rs_address,
    output logic [NUM_READ*DATA_W-1:0]     rs_data,
    output logic [NUM_READ-1:0]            rs_busy,
    input  logic                           rsv_en,
    input  logic [ADDR_W-1:0]              rsv_rd,
    input  logic                           flush,
    output logic [$clog2(NUM_REGS):0]      busy_count
);

    localparam int CNT_W = $clog2(NUM_REGS) + 1;

    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;
    logic [CNT_W-1:0]    r_busy_count;
    logic [CNT_W-1:0]    w_count_next;

    // Next busy vector: flush wins over everything; otherwise a write clears
    // its register and a reservation (applied last) sets it again.
    always_comb begin
        w_busy_next = r_busy;
        if (flush) begin
            w_busy_next = '0;
        end else begin
            if (en && (rd != '0)) begin
                w_busy_next[rd] = 1'b0;
            end
            if (rsv_en && (rsv_rd != '0)) begin
                w_busy_next[rsv_rd] = 1'b1;
            end
        end
        w_busy_next[0] = 1'b0;
    end

    // Population count of the next busy vector so the registered count
    // always tracks the registered bits exactly.
    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_count_next = w_count_next + CNT_W'(w_busy_next[i]);
        end
    end

    // Register storage; entry 0 is reset to zero and never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (en && (rd != '0)) begin
            r_mem[rd] <= register_file_data;
        end
    end

    // Scoreboard bits and their population count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_next;
            r_busy_count <= w_count_next;
        end
    end

    assign busy_count = r_busy_count;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_read
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_data;
            logic              w_busy;

            assign w_addr = rs_address[gi*ADDR_W +: ADDR_W];

            // Read mux: zero register and reset force 0; a matching write
            // in flight is forwarded and hides the busy bit it will clear.
            always_comb begin
                w_data = '0;
                w_busy = 1'b0;
                if (rst || (w_addr == '0)) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end else if ((BYPASS != 0) && en && (rd == w_addr)) begin
                    w_data = register_file_data;
                    w_busy = 1'b0;
                end else begin
                    w_data = r_mem[w_addr];
                    w_busy = r_busy[w_addr];
                end
            end

            assign rs_data[gi*DATA_W +: DATA_W] = w_data;
            assign rs_busy[gi]                  = w_busy;
        end
    endgenerate

endmodule

// File: tb/tb_register_file_sb.sv
// Testbench for register_file_sb: directed vectors on a default (bypass)
// instance and a no-bypass instance sharing stimulus, plus a randomised
// run of a 16x64, 3-read-port instance against a reference model.
module tb_register_file_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Shared stimulus for instances A (BYPASS=1) and B (BYPASS=0)
    logic        en = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] wdata = '0;
    logic [9:0]  rs_address = '0;
    logic        rsv_en = 1'b0;
    logic [4:0]  rsv_rd = '0;
    logic        flush = 1'b0;

    logic [63:0] a_rs_data, b_rs_data;
    logic [1:0]  a_rs_busy, b_rs_busy;
    logic [5:0]  a_cnt, b_cnt;

    // Stimulus for instance C (NUM_REGS=16, DATA_W=64, NUM_READ=3)
    logic         c_en = 1'b0;
    logic [3:0]   c_rd = '0;
    logic [63:0]  c_wdata = '0;
    logic [11:0]  c_rs_address = '0;
    logic         c_rsv_en = 1'b0;
    logic [3:0]   c_rsv_rd = '0;
    logic         c_flush = 1'b0;
    logic [191:0] c_rs_data;
    logic [2:0]   c_rs_busy;
    logic [4:0]   c_cnt;

    int err_cnt = 0;
    int chk_cnt = 0;

    register_file_sb #(.BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .rd(rd), .register_file_data(wdata),
        .rs_address(rs_address), .rs_data(a_rs_data), .rs_busy(a_rs_busy),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd), .flush(flush), .busy_count(a_cnt)
    );

    register_file_sb #(.BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .rd(rd), .register_file_data(wdata),
        .rs_address(rs_address), .rs_data(b_rs_data), .rs_busy(b_rs_busy),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd), .flush(flush), .busy_count(b_cnt)
    );

    register_file_sb #(.DATA_W(64), .NUM_REGS(16), .NUM_READ(3), .BYPASS(1)) u_c (
        .clk(clk), .rst(rst), .en(c_en), .rd(c_rd), .register_file_data(c_wdata),
        .rs_address(c_rs_address), .rs_data(c_rs_data), .rs_busy(c_rs_busy),
        .rsv_en(c_rsv_en), .rsv_rd(c_rsv_rd), .flush(c_flush), .busy_count(c_cnt)
    );

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input logic [4:0] p0, input logic [4:0] p1);
        rs_address = {p1, p0};
    endtask

    // Reference model for instance C
    logic [63:0] m_mem [16];
    logic        m_busy [16];

    initial begin
        int          pop;
        logic [3:0]  addr;
        logic [63:0] e_data;
        logic        e_busy;

        for (int i = 0; i < 16; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end

        // Reset state
        tick();
        check_value("reset_cnt", 64'(a_cnt), 64'd0);
        check_value("reset_data", a_rs_data, 64'd0);
        tick();
        #2 rst = 1'b0;
        tick();

        // Write then read on both ports
        en = 1'b1; rd = 5'd3; wdata = 32'h12345678;
        tick();
        en = 1'b0;
        set_rs(5'd3, 5'd3);
        #1;
        check_value("wr_a_p0", 64'(a_rs_data[31:0]), 64'h12345678);
        check_value("wr_a_p1", 64'(a_rs_data[63:32]), 64'h12345678);
        check_value("wr_b_p0", 64'(b_rs_data[31:0]), 64'h12345678);

        // Write to x0 is ignored
        en = 1'b1; rd = 5'd0; wdata = 32'hFFFFFFFF;
        set_rs(5'd0, 5'd0);
        #1;
        check_value("x0_bypass", 64'(a_rs_data[31:0]), 64'd0);
        tick();
        en = 1'b0;
        #1;
        check_value("x0_read", 64'(a_rs_data[31:0]), 64'd0);

        // Same-cycle bypass (A) versus registered value (B)
        en = 1'b1; rd = 5'd9; wdata = 32'hA5A5A5A5;
        set_rs(5'd9, 5'd3);
        #1;
        check_value("byp_a", 64'(a_rs_data[31:0]), 64'hA5A5A5A5);
        check_value("byp_b_old", 64'(b_rs_data[31:0]), 64'd0);
        tick();
        en = 1'b0;
        #1;
        check_value("byp_b_new", 64'(b_rs_data[31:0]), 64'hA5A5A5A5);

        // Scoreboard: reserve x4 and x6
        rsv_en = 1'b1; rsv_rd = 5'd4;
        tick();
        rsv_rd = 5'd6;
        tick();
        rsv_en = 1'b0;
        set_rs(5'd4, 5'd6);
        #1;
        check_value("rsv_cnt", 64'(a_cnt), 64'd2);
        check_value("rsv_a_busy4", 64'(a_rs_busy[0]), 64'd1);
        check_value("rsv_b_busy4", 64'(b_rs_busy[0]), 64'd1);
        // Write x4: A masks busy in the write cycle, B does not
        en = 1'b1; rd = 5'd4; wdata = 32'h00000044;
        #1;
        check_value("wclr_a_now", 64'(a_rs_busy[0]), 64'd0);
        check_value("wclr_b_now", 64'(b_rs_busy[0]), 64'd1);
        check_value("wclr_b_data", 64'(b_rs_data[31:0]), 64'd0);
        tick();
        en = 1'b0;
        #1;
        check_value("wclr_a_busy", 64'(a_rs_busy[0]), 64'd0);
        check_value("wclr_b_busy", 64'(b_rs_busy[0]), 64'd0);
        check_value("wclr_cnt", 64'(a_cnt), 64'd1);
        check_value("wclr_busy6", 64'(a_rs_busy[1]), 64'd1);

        // Reserve and write x8 in the same cycle: stays busy, data updated
        en = 1'b1; rd = 5'd8; wdata = 32'h00000088;
        rsv_en = 1'b1; rsv_rd = 5'd8;
        tick();
        en = 1'b0; rsv_en = 1'b0;
        set_rs(5'd8, 5'd6);
        #1;
        check_value("rw8_cnt", 64'(a_cnt), 64'd2);
        check_value("rw8_busy", 64'(a_rs_busy[0]), 64'd1);
        check_value("rw8_data", 64'(a_rs_data[31:0]), 64'h88);

        // Flush with a same-cycle reservation of x10
        flush = 1'b1; rsv_en = 1'b1; rsv_rd = 5'd10;
        tick();
        flush = 1'b0; rsv_en = 1'b0;
        set_rs(5'd10, 5'd6);
        #1;
        check_value("flush_cnt", 64'(a_cnt), 64'd0);
        check_value("flush_busy10", 64'(a_rs_busy[0]), 64'd0);
        check_value("flush_busy6", 64'(a_rs_busy[1]), 64'd0);

        // Mid-run reset after writing x5 and reserving x7
        en = 1'b1; rd = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        en = 1'b0;
        rsv_en = 1'b1; rsv_rd = 5'd7;
        tick();
        rsv_en = 1'b0;
        set_rs(5'd5, 5'd7);
        #1;
        check_value("pre_rst_x5", 64'(a_rs_data[31:0]), 64'hDEADBEEF);
        check_value("pre_rst_busy7", 64'(a_rs_busy[1]), 64'd1);
        check_value("pre_rst_cnt", 64'(a_cnt), 64'd1);
        #1 rst = 1'b1;
        en = 1'b1; rd = 5'd5; wdata = 32'h11111111;
        rsv_en = 1'b1; rsv_rd = 5'd7;
        #1;
        check_value("rst_x5", 64'(a_rs_data[31:0]), 64'd0);
        check_value("rst_busy7", 64'(a_rs_busy[1]), 64'd0);
        check_value("rst_cnt", 64'(a_cnt), 64'd0);
        for (int i = 0; i < 32; i++) begin
            set_rs(5'(i), 5'(31 - i));
            #1;
            check_value($sformatf("rst_rd_x%0d", i), a_rs_data, 64'd0);
        end
        tick();
        en = 1'b0; rsv_en = 1'b0;
        rst = 1'b0;
        tick();
        set_rs(5'd5, 5'd7);
        #1;
        check_value("post_rst_a_x5", 64'(a_rs_data[31:0]), 64'd0);
        check_value("post_rst_b_x5", 64'(b_rs_data[31:0]), 64'd0);
        check_value("post_rst_busy7", 64'(a_rs_busy[1]), 64'd0);
        check_value("post_rst_cnt", 64'(b_cnt), 64'd0);

        // Randomised run of the 16x64x3 instance against the model
        for (int n = 0; n < 200; n++) begin
            c_en         = ($urandom_range(0, 1) == 1);
            c_rd         = 4'($urandom_range(0, 15));
            c_wdata      = {$urandom, $urandom};
            c_rsv_en     = ($urandom_range(0, 1) == 1);
            c_rsv_rd     = 4'($urandom_range(0, 15));
            c_flush      = ($urandom_range(0, 15) == 0);
            c_rs_address = 12'($urandom_range(0, 4095));
            #1;
            for (int k = 0; k < 3; k++) begin
                addr = c_rs_address[k*4 +: 4];
                if (addr == 4'd0) begin
                    e_data = '0; e_busy = 1'b0;
                end else if (c_en && (c_rd == addr)) begin
                    e_data = c_wdata; e_busy = 1'b0;
                end else begin
                    e_data = m_mem[addr]; e_busy = m_busy[addr];
                end
                check_value($sformatf("rnd%0d_p%0d_data", n, k), c_rs_data[k*64 +: 64], e_data);
                check_value($sformatf("rnd%0d_p%0d_busy", n, k), 64'(c_rs_busy[k]), 64'(e_busy));
            end
            pop = 0;
            for (int i = 0; i < 16; i++) pop += int'(m_busy[i]);
            check_value($sformatf("rnd%0d_cnt", n), 64'(c_cnt), 64'(pop));
            // Model next state
            if (c_en && (c_rd != 4'd0)) begin
                m_mem[c_rd]  = c_wdata;
                m_busy[c_rd] = 1'b0;
            end
            if (c_flush) begin
                for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
            end else if (c_rsv_en && (c_rsv_rd != 4'd0)) begin
                m_busy[c_rsv_rd] = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
